// File: rtl/blit_pkg.sv
// Shared types and constants for the blitter SDRAM port merge: FSM state
// encoding, read byte-lane mask and run-counter width with its saturating increment.
package blit_pkg;

    localparam int RUN_W = 4;
    localparam logic [RUN_W-1:0] RUN_SAT = '1;
    localparam logic [3:0] BLIT_RD_BE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_READ_REQ  = 2'd2,
        ST_READ_WAIT = 2'd3
    } blit_state_t;

    function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] v);
        return (v == RUN_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/blit_sdram_port_arbiter.sv
// Merges the blitter write and read ports into one SDRAM arbiter client.
// One transaction at a time; run counters keep either side from starving the other.
module blit_sdram_port_arbiter
    import blit_pkg::*;
#(
    parameter int RD_RUN_MAX = 4,
    parameter int WR_RUN_MAX = 8
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        blitw_sdram_req,
    input  logic [25:0] blitw_sdram_addr,
    input  logic [31:0] blitw_sdram_wdata,
    input  logic [3:0]  blitw_sdram_byte_enable,
    output logic        blitw_sdram_ack,

    input  logic        blitr_sdram_req,
    input  logic [25:0] blitr_sdram_addr,
    output logic        blitr_sdram_ack,
    output logic [31:0] blitr_sdram_rdata,
    output logic        blitr_sdram_rdvalid,
    output logic        blitr_sdram_complete,

    output logic        sdram_req,
    output logic        sdram_write,
    output logic [25:0] sdram_addr,
    output logic [31:0] sdram_wdata,
    output logic [3:0]  sdram_byte_enable,
    input  logic        sdram_ack,
    input  logic [31:0] sdram_rdata,
    input  logic        sdram_rdvalid,
    input  logic        sdram_complete,

    output logic        busy
);

    localparam logic [RUN_W-1:0] RD_LIM = RUN_W'(RD_RUN_MAX);
    localparam logic [RUN_W-1:0] WR_LIM = RUN_W'(WR_RUN_MAX);

    blit_state_t      r_state;
    blit_state_t      w_next_state;
    logic [RUN_W-1:0] r_rd_run;
    logic [RUN_W-1:0] r_wr_run;

    logic w_hazard;
    logic w_grant_any;
    logic w_grant_write;

    // Same 32-bit word on both sides: the write must land before the read samples it.
    always_comb begin
        w_hazard      = (blitw_sdram_addr[25:2] == blitr_sdram_addr[25:2]);
        w_grant_any   = blitw_sdram_req | blitr_sdram_req;
        w_grant_write = 1'b0;
        if (blitw_sdram_req && !blitr_sdram_req) begin
            w_grant_write = 1'b1;
        end else if (blitw_sdram_req && blitr_sdram_req) begin
            if (w_hazard)
                w_grant_write = 1'b1;
            else
                w_grant_write = (r_rd_run >= RD_LIM) && !(r_wr_run >= WR_LIM);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_any)
                    w_next_state = w_grant_write ? ST_WRITE : ST_READ_REQ;
            end
            ST_WRITE: begin
                if (sdram_ack)
                    w_next_state = ST_IDLE;
            end
            ST_READ_REQ: begin
                if (sdram_ack)
                    w_next_state = sdram_complete ? ST_IDLE : ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                if (sdram_complete)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_rd_run <= '0;
            r_wr_run <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && w_grant_any) begin
                if (w_grant_write) begin
                    r_wr_run <= blitr_sdram_req ? run_inc(r_wr_run) : '0;
                    r_rd_run <= '0;
                end else begin
                    r_rd_run <= blitw_sdram_req ? run_inc(r_rd_run) : '0;
                    r_wr_run <= '0;
                end
            end
        end
    end

    // Outputs are gated by reset directly so they read 0 for the whole reset window.
    always_comb begin
        sdram_req            = 1'b0;
        sdram_write          = 1'b0;
        sdram_addr           = '0;
        sdram_wdata          = '0;
        sdram_byte_enable    = '0;
        blitw_sdram_ack      = 1'b0;
        blitr_sdram_ack      = 1'b0;
        blitr_sdram_rdata    = '0;
        blitr_sdram_rdvalid  = 1'b0;
        blitr_sdram_complete = 1'b0;
        busy                 = 1'b0;
        if (reset) begin
            busy = (r_state != ST_IDLE);
            case (r_state)
                ST_WRITE: begin
                    sdram_req         = 1'b1;
                    sdram_write       = 1'b1;
                    sdram_addr        = blitw_sdram_addr;
                    sdram_wdata       = blitw_sdram_wdata;
                    sdram_byte_enable = blitw_sdram_byte_enable;
                    blitw_sdram_ack   = sdram_ack;
                end
                ST_READ_REQ: begin
                    sdram_req            = 1'b1;
                    sdram_addr           = blitr_sdram_addr;
                    sdram_byte_enable    = BLIT_RD_BE;
                    blitr_sdram_ack      = sdram_ack;
                    blitr_sdram_rdata    = sdram_rdata;
                    blitr_sdram_rdvalid  = sdram_rdvalid;
                    blitr_sdram_complete = sdram_complete;
                end
                ST_READ_WAIT: begin
                    blitr_sdram_rdata    = sdram_rdata;
                    blitr_sdram_rdvalid  = sdram_rdvalid;
                    blitr_sdram_complete = sdram_complete;
                end
                default: ;
            endcase
        end
    end

    // Requesters must hold req until their ack.
    a_wr_hold: assert property (@(posedge clock) disable iff (!reset)
        (r_state == ST_WRITE) |-> blitw_sdram_req);
    a_rd_hold: assert property (@(posedge clock) disable iff (!reset)
        (r_state == ST_READ_REQ) |-> blitr_sdram_req);

endmodule

// File: tb/tb_blit_sdram_port_arbiter.sv
// Bench for blit_sdram_port_arbiter: directed scenarios plus a randomized run
// checked against a grant-history model of the priority and anti-starvation rules.
module tb_blit_sdram_port_arbiter;

    localparam int RD_MAX = 4;
    localparam int WR_MAX = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        blitw_sdram_req = 1'b0;
    logic [25:0] blitw_sdram_addr = '0;
    logic [31:0] blitw_sdram_wdata = '0;
    logic [3:0]  blitw_sdram_byte_enable = '0;
    logic        blitw_sdram_ack;
    logic        blitr_sdram_req = 1'b0;
    logic [25:0] blitr_sdram_addr = '0;
    logic        blitr_sdram_ack;
    logic [31:0] blitr_sdram_rdata;
    logic        blitr_sdram_rdvalid;
    logic        blitr_sdram_complete;
    logic        sdram_req;
    logic        sdram_write;
    logic [25:0] sdram_addr;
    logic [31:0] sdram_wdata;
    logic [3:0]  sdram_byte_enable;
    logic        sdram_ack = 1'b0;
    logic [31:0] sdram_rdata = '0;
    logic        sdram_rdvalid = 1'b0;
    logic        sdram_complete = 1'b0;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic is_w;
        logic other_pend;
    } grant_t;
    grant_t hist[$];

    blit_sdram_port_arbiter #(.RD_RUN_MAX(RD_MAX), .WR_RUN_MAX(WR_MAX)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .blitw_sdram_req         (blitw_sdram_req),
        .blitw_sdram_addr        (blitw_sdram_addr),
        .blitw_sdram_wdata       (blitw_sdram_wdata),
        .blitw_sdram_byte_enable (blitw_sdram_byte_enable),
        .blitw_sdram_ack         (blitw_sdram_ack),
        .blitr_sdram_req         (blitr_sdram_req),
        .blitr_sdram_addr        (blitr_sdram_addr),
        .blitr_sdram_ack         (blitr_sdram_ack),
        .blitr_sdram_rdata       (blitr_sdram_rdata),
        .blitr_sdram_rdvalid     (blitr_sdram_rdvalid),
        .blitr_sdram_complete    (blitr_sdram_complete),
        .sdram_req               (sdram_req),
        .sdram_write             (sdram_write),
        .sdram_addr              (sdram_addr),
        .sdram_wdata             (sdram_wdata),
        .sdram_byte_enable       (sdram_byte_enable),
        .sdram_ack               (sdram_ack),
        .sdram_rdata             (sdram_rdata),
        .sdram_rdvalid           (sdram_rdvalid),
        .sdram_complete          (sdram_complete),
        .busy                    (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        blitw_sdram_req = 1'b0;
        blitr_sdram_req = 1'b0;
        sdram_ack       = 1'b0;
        sdram_rdvalid   = 1'b0;
        sdram_complete  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        hist.delete();
    endtask

    // Length of the current run of grants to 'side' made while the other side waited.
    function automatic int streak(input bit side);
        int s = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i].is_w == side && hist[i].other_pend) s++;
            else break;
        end
        return (s > 15) ? 15 : s;
    endfunction

    // Plays the downstream arbiter for one transaction; beats == 0 means the
    // read completes in its ack cycle.
    task automatic serve(input int ack_dly, input int beats, output bit got_w);
        int n = 0;
        logic [31:0] d;
        got_w = 1'b0;
        while (sdram_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        n_cmp++;
        if (sdram_req !== 1'b1) begin
            n_err++;
            $display("FAIL serve_grant: sdram_req=%b required 1", sdram_req);
            return;
        end
        got_w = sdram_write;
        n_cmp++;
        if (got_w ? (sdram_addr !== blitw_sdram_addr || sdram_wdata !== blitw_sdram_wdata ||
                     sdram_byte_enable !== blitw_sdram_byte_enable)
                  : (sdram_addr !== blitr_sdram_addr || sdram_byte_enable !== 4'hF)) begin
            n_err++;
            $display("FAIL serve_fields: write=%b addr=%h wdata=%h be=%h", got_w, sdram_addr,
                     sdram_wdata, sdram_byte_enable);
        end
        for (int i = 0; i < ack_dly; i++) begin
            n_cmp++;
            if (blitw_sdram_ack !== 1'b0 || blitr_sdram_ack !== 1'b0) begin
                n_err++;
                $display("FAIL serve_early_ack: w=%b r=%b required 0 0", blitw_sdram_ack, blitr_sdram_ack);
            end
            tick();
        end
        sdram_ack      = 1'b1;
        sdram_complete = (!got_w && beats == 0);
        #1;
        n_cmp++;
        if ({blitw_sdram_ack, blitr_sdram_ack} !== (got_w ? 2'b10 : 2'b01)) begin
            n_err++;
            $display("FAIL serve_ack_route: w=%b r=%b write=%b", blitw_sdram_ack, blitr_sdram_ack, got_w);
        end
        tick();
        sdram_ack      = 1'b0;
        sdram_complete = 1'b0;
        if (!got_w && beats > 0) begin
            #1;
            n_cmp++;
            if (sdram_req !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL serve_read_wait: sdram_req=%b busy=%b required 0 1", sdram_req, busy);
            end
            for (int b = 0; b < beats; b++) begin
                d             = $urandom;
                sdram_rdata   = d;
                sdram_rdvalid = 1'b1;
                #1;
                n_cmp++;
                if (blitr_sdram_rdata !== d || blitr_sdram_rdvalid !== 1'b1) begin
                    n_err++;
                    $display("FAIL serve_rdata: got %h/%b required %h/1", blitr_sdram_rdata,
                             blitr_sdram_rdvalid, d);
                end
                tick();
                sdram_rdvalid = 1'b0;
            end
            sdram_complete = 1'b1;
            #1;
            n_cmp++;
            if (blitr_sdram_complete !== 1'b1) begin
                n_err++;
                $display("FAIL serve_complete: got %b required 1", blitr_sdram_complete);
            end
            tick();
            sdram_complete = 1'b0;
        end
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL serve_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        reset                   = 1'b0;
        blitw_sdram_req         = 1'b1;
        blitr_sdram_req         = 1'b1;
        blitw_sdram_addr        = 26'h1234567;
        blitw_sdram_wdata       = 32'hAAAA5555;
        blitw_sdram_byte_enable = 4'hF;
        sdram_ack               = 1'b1;
        sdram_rdvalid           = 1'b1;
        sdram_complete          = 1'b1;
        sdram_rdata             = 32'hFFFFFFFF;
        tick();
        tick();
        n_cmp++;
        if ({sdram_req, blitw_sdram_ack, blitr_sdram_ack, blitr_sdram_rdvalid,
             blitr_sdram_complete, busy, sdram_write} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: req=%b wack=%b rack=%b rdv=%b cmp=%b busy=%b wr=%b required all 0",
                     sdram_req, blitw_sdram_ack, blitr_sdram_ack, blitr_sdram_rdvalid,
                     blitr_sdram_complete, busy, sdram_write);
        end
        n_cmp++;
        if (sdram_addr !== '0 || sdram_wdata !== '0 || sdram_byte_enable !== '0 || blitr_sdram_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_data: addr=%h wdata=%h be=%h rdata=%h required 0", sdram_addr,
                     sdram_wdata, sdram_byte_enable, blitr_sdram_rdata);
        end
        blitw_sdram_req = 1'b0;
        blitr_sdram_req = 1'b0;
        sdram_ack       = 1'b0;
        sdram_rdvalid   = 1'b0;
        sdram_complete  = 1'b0;
        reset           = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || sdram_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_idle: busy=%b req=%b required 0 0", busy, sdram_req);
        end
    endtask

    task automatic test_write_only();
        do_reset();
        blitw_sdram_addr        = 26'h0000100;
        blitw_sdram_wdata       = 32'hDEADBEEF;
        blitw_sdram_byte_enable = 4'b0011;
        blitw_sdram_req         = 1'b1;
        #1;
        n_cmp++;
        if (sdram_req !== 1'b0) begin
            n_err++;
            $display("FAIL wr_req_latency: sdram_req=%b required 0 in the request cycle", sdram_req);
        end
        tick();
        n_cmp++;
        if (sdram_req !== 1'b1 || sdram_write !== 1'b1 || sdram_addr !== 26'h0000100 ||
            sdram_wdata !== 32'hDEADBEEF || sdram_byte_enable !== 4'b0011 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL wr_fields: req=%b wr=%b addr=%h wdata=%h be=%b busy=%b", sdram_req,
                     sdram_write, sdram_addr, sdram_wdata, sdram_byte_enable, busy);
        end
        n_cmp++;
        if (blitw_sdram_ack !== 1'b0) begin
            n_err++;
            $display("FAIL wr_ack_before_downstream: got %b required 0", blitw_sdram_ack);
        end
        tick();
        sdram_ack = 1'b1;
        #1;
        n_cmp++;
        if (blitw_sdram_ack !== 1'b1 || blitr_sdram_ack !== 1'b0) begin
            n_err++;
            $display("FAIL wr_ack_same_cycle: wack=%b rack=%b required 1 0", blitw_sdram_ack, blitr_sdram_ack);
        end
        tick();
        sdram_ack       = 1'b0;
        blitw_sdram_req = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || sdram_req !== 1'b0) begin
            n_err++;
            $display("FAIL wr_back_idle: busy=%b req=%b required 0 0", busy, sdram_req);
        end
    endtask

    task automatic test_read_only();
        do_reset();
        blitr_sdram_addr = 26'h0000200;
        blitr_sdram_req  = 1'b1;
        tick();
        n_cmp++;
        if (sdram_req !== 1'b1 || sdram_write !== 1'b0 || sdram_addr !== 26'h0000200 ||
            sdram_byte_enable !== 4'hF) begin
            n_err++;
            $display("FAIL rd_fields: req=%b wr=%b addr=%h be=%h", sdram_req, sdram_write, sdram_addr,
                     sdram_byte_enable);
        end
        sdram_ack = 1'b1;
        #1;
        n_cmp++;
        if (blitr_sdram_ack !== 1'b1 || blitw_sdram_ack !== 1'b0) begin
            n_err++;
            $display("FAIL rd_ack: rack=%b wack=%b required 1 0", blitr_sdram_ack, blitw_sdram_ack);
        end
        tick();
        sdram_ack       = 1'b0;
        blitr_sdram_req = 1'b0;
        sdram_rdata     = 32'h12345678;
        sdram_rdvalid   = 1'b1;
        #1;
        n_cmp++;
        if (sdram_req !== 1'b0 || blitr_sdram_rdvalid !== 1'b1 || blitr_sdram_rdata !== 32'h12345678) begin
            n_err++;
            $display("FAIL rd_data_route: req=%b rdv=%b rdata=%h required 0 1 12345678", sdram_req,
                     blitr_sdram_rdvalid, blitr_sdram_rdata);
        end
        tick();
        sdram_rdvalid  = 1'b0;
        sdram_complete = 1'b1;
        #1;
        n_cmp++;
        if (blitr_sdram_complete !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rd_complete: cmp=%b busy=%b required 1 1", blitr_sdram_complete, busy);
        end
        tick();
        sdram_complete = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rd_back_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        blitw_sdram_addr        = 26'h0000040;
        blitw_sdram_wdata       = 32'h0BADF00D;
        blitw_sdram_byte_enable = 4'hF;
        blitr_sdram_addr        = 26'h0000043;
        blitw_sdram_req         = 1'b1;
        blitr_sdram_req         = 1'b1;
        tick();
        n_cmp++;
        if (sdram_write !== 1'b1 || sdram_addr !== 26'h0000040) begin
            n_err++;
            $display("FAIL hazard_write_first: wr=%b addr=%h required 1 0000040", sdram_write, sdram_addr);
        end
        sdram_ack = 1'b1;
        tick();
        sdram_ack       = 1'b0;
        blitw_sdram_req = 1'b0;
        tick();
        n_cmp++;
        if (sdram_req !== 1'b1 || sdram_write !== 1'b0 || sdram_addr !== 26'h0000043) begin
            n_err++;
            $display("FAIL hazard_read_second: req=%b wr=%b addr=%h", sdram_req, sdram_write, sdram_addr);
        end
        sdram_ack      = 1'b1;
        sdram_complete = 1'b1;
        tick();
        sdram_ack       = 1'b0;
        sdram_complete  = 1'b0;
        blitr_sdram_req = 1'b0;
    endtask

    task automatic test_ack_complete();
        do_reset();
        blitr_sdram_addr = 26'h0000600;
        blitr_sdram_req  = 1'b1;
        tick();
        sdram_ack      = 1'b1;
        sdram_complete = 1'b1;
        #1;
        n_cmp++;
        if (blitr_sdram_ack !== 1'b1 || blitr_sdram_complete !== 1'b1) begin
            n_err++;
            $display("FAIL ackcmp_pass: rack=%b cmp=%b required 1 1", blitr_sdram_ack, blitr_sdram_complete);
        end
        tick();
        sdram_ack       = 1'b0;
        sdram_complete  = 1'b0;
        blitr_sdram_req = 1'b0;
        sdram_rdvalid   = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || blitr_sdram_rdvalid !== 1'b0 || blitr_sdram_complete !== 1'b0) begin
            n_err++;
            $display("FAIL ackcmp_idle: busy=%b rdv=%b cmp=%b required 0 0 0", busy,
                     blitr_sdram_rdvalid, blitr_sdram_complete);
        end
        sdram_rdvalid = 1'b0;
    endtask

    task automatic test_run_limit();
        bit exp_order[10];
        bit got_w;
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        blitw_sdram_addr        = 26'h0001000;
        blitw_sdram_wdata       = 32'hCAFEF00D;
        blitw_sdram_byte_enable = 4'b1100;
        blitr_sdram_addr        = 26'h0002000;
        blitw_sdram_req         = 1'b1;
        blitr_sdram_req         = 1'b1;
        for (int g = 0; g < 10; g++) begin
            serve(0, 0, got_w);
            n_cmp++;
            if (got_w !== exp_order[g]) begin
                n_err++;
                $display("FAIL run_limit_order[%0d]: write=%b required %b", g, got_w, exp_order[g]);
            end
        end
        blitw_sdram_req = 1'b0;
        blitr_sdram_req = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        bit got_w;
        do_reset();
        blitr_sdram_addr = 26'h0000300;
        blitr_sdram_req  = 1'b1;
        tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack       = 1'b0;
        blitr_sdram_req = 1'b0;
        sdram_rdvalid   = 1'b1;
        sdram_rdata     = 32'h55AA55AA;
        reset           = 1'b0;
        tick();
        n_cmp++;
        if ({sdram_req, busy, blitr_sdram_rdvalid, blitr_sdram_complete, blitr_sdram_ack,
             blitw_sdram_ack} !== 6'b0 || blitr_sdram_rdata !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: req=%b busy=%b rdv=%b cmp=%b rdata=%h required 0",
                     sdram_req, busy, blitr_sdram_rdvalid, blitr_sdram_complete, blitr_sdram_rdata);
        end
        reset         = 1'b1;
        sdram_rdvalid = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_idle: busy=%b required 0", busy);
        end
        blitw_sdram_addr        = 26'h0000500;
        blitw_sdram_wdata       = 32'h01020304;
        blitw_sdram_byte_enable = 4'b0101;
        blitw_sdram_req         = 1'b1;
        serve(1, 0, got_w);
        n_cmp++;
        if (got_w !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_write_after: write=%b required 1", got_w);
        end
        blitw_sdram_req = 1'b0;
    endtask

    task automatic test_random();
        bit wp = 1'b0;
        bit rp = 1'b0;
        bit got_w, exp_w, haz;
        do_reset();
        for (int k = 0; k < 80; k++) begin
            if (!wp && $urandom_range(0, 1) == 1) begin
                wp                      = 1'b1;
                blitw_sdram_addr        = 26'($urandom);
                blitw_sdram_wdata       = $urandom;
                blitw_sdram_byte_enable = 4'($urandom_range(1, 15));
            end
            if (!rp && $urandom_range(0, 1) == 1) begin
                rp = 1'b1;
                if (wp && $urandom_range(0, 2) == 0)
                    blitr_sdram_addr = {blitw_sdram_addr[25:2], 2'($urandom)};
                else
                    blitr_sdram_addr = 26'($urandom);
            end
            if (!wp && !rp) begin
                rp               = 1'b1;
                blitr_sdram_addr = 26'($urandom);
            end
            blitw_sdram_req = wp;
            blitr_sdram_req = rp;
            haz = (blitw_sdram_addr[25:2] == blitr_sdram_addr[25:2]);
            if (wp && !rp)      exp_w = 1'b1;
            else if (rp && !wp) exp_w = 1'b0;
            else if (haz)       exp_w = 1'b1;
            else                exp_w = (streak(1'b0) >= RD_MAX) && (streak(1'b1) < WR_MAX);
            serve($urandom_range(0, 2), $urandom_range(0, 3), got_w);
            n_cmp++;
            if (got_w !== exp_w) begin
                n_err++;
                $display("FAIL random_grant[%0d]: write=%b required %b (wp=%b rp=%b haz=%b)", k, got_w,
                         exp_w, wp, rp, haz);
            end
            hist.push_back('{is_w: exp_w, other_pend: (exp_w ? rp : wp)});
            if (got_w) begin
                wp              = 1'b0;
                blitw_sdram_req = 1'b0;
            end else begin
                rp              = 1'b0;
                blitr_sdram_req = 1'b0;
            end
        end
        blitw_sdram_req = 1'b0;
        blitr_sdram_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_read_only();
        test_hazard();
        test_ack_complete();
        test_run_limit();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
